// File: rtl/nebula_pkg.sv
// Shared frontend branch-predictor parameters and types.
package nebula_pkg;

    localparam int VADDR_WIDTH  = 39;
    localparam int RAS_DEPTH    = 8;
    localparam int NUM_RAS_CKPT = 4;

    localparam int RAS_PTR_W = $clog2(RAS_DEPTH);
    localparam int RAS_CNT_W = RAS_PTR_W + 1;

    // RAS checkpoint as seen by the rest of the frontend in the default
    // configuration: top-of-stack pointer, occupancy and the top entry value.
    typedef struct packed {
        logic [RAS_PTR_W-1:0]   tos;
        logic [RAS_CNT_W-1:0]   count;
        logic [VADDR_WIDTH-1:0] top;
    } ras_ckpt_t;

endpackage

// File: rtl/nebula_ras_ckpt.sv
// Circular return address stack with in-order speculative checkpoints.
// Only {tos, count, top entry} are saved per checkpoint, so entries below
// the top that were overwritten on the wrong path stay corrupted.
module nebula_ras_ckpt
    import nebula_pkg::*;
#(
    parameter int DEPTH    = RAS_DEPTH,
    parameter int ADDR_W   = VADDR_WIDTH,
    parameter int NUM_CKPT = NUM_RAS_CKPT
) (
    input  logic                        clk_i,
    input  logic                        rst_i,
    input  logic                        flush_i,
    input  logic                        push_i,
    input  logic [ADDR_W-1:0]           push_addr_i,
    input  logic                        pop_i,
    output logic [ADDR_W-1:0]           top_o,
    output logic                        top_valid_o,
    input  logic                        ckpt_alloc_i,
    output logic [$clog2(NUM_CKPT)-1:0] ckpt_id_o,
    output logic                        ckpt_full_o,
    input  logic                        restore_i,
    input  logic [$clog2(NUM_CKPT)-1:0] restore_id_i,
    input  logic                        release_i
);

    localparam int PTR_W  = $clog2(DEPTH);
    localparam int CNT_W  = PTR_W + 1;
    localparam int ID_W   = $clog2(NUM_CKPT);
    localparam int LIVE_W = ID_W + 1;

    typedef struct packed {
        logic [PTR_W-1:0]  tos;
        logic [CNT_W-1:0]  count;
        logic [ADDR_W-1:0] top;
    } ckpt_t;

    logic [ADDR_W-1:0] r_entries [DEPTH];
    logic [PTR_W-1:0]  r_tos;
    logic [CNT_W-1:0]  r_count;
    ckpt_t             r_ckpt [NUM_CKPT];
    logic [ID_W-1:0]   r_head;
    logic [ID_W-1:0]   r_tail;
    logic [LIVE_W-1:0] r_live;

    logic              w_normal;
    logic              w_alloc_ok;
    logic              w_rel_ok;
    logic              w_nonempty;
    ckpt_t             w_rst_ckpt;
    logic [PTR_W-1:0]  w_tos_nxt;
    logic [CNT_W-1:0]  w_count_nxt;
    logic              w_wr_en;
    logic [PTR_W-1:0]  w_wr_idx;
    logic [ADDR_W-1:0] w_wr_data;
    logic [ID_W-1:0]   w_head_nxt;
    logic [ID_W-1:0]   w_tail_nxt;
    logic [LIVE_W-1:0] w_live_nxt;

    assign top_o       = r_entries[r_tos];
    assign top_valid_o = (r_count != '0);
    assign ckpt_id_o   = r_tail;
    assign ckpt_full_o = (r_live == LIVE_W'(NUM_CKPT));

    assign w_normal   = !flush_i && !restore_i;
    assign w_alloc_ok = w_normal && ckpt_alloc_i && !ckpt_full_o;
    assign w_rel_ok   = w_normal && release_i && (r_live != '0);
    assign w_nonempty = (r_count != '0);
    assign w_rst_ckpt = r_ckpt[restore_id_i];

    // Next stack pointer/occupancy and the single entry write for this cycle.
    always_comb begin
        w_tos_nxt   = r_tos;
        w_count_nxt = r_count;
        w_wr_en     = 1'b0;
        w_wr_idx    = r_tos;
        w_wr_data   = push_addr_i;
        if (restore_i) begin
            w_tos_nxt   = w_rst_ckpt.tos;
            w_count_nxt = w_rst_ckpt.count;
            w_wr_en     = 1'b1;
            w_wr_idx    = w_rst_ckpt.tos;
            w_wr_data   = w_rst_ckpt.top;
        end else if (push_i && pop_i && w_nonempty) begin
            w_wr_en = 1'b1;
        end else if (push_i) begin
            w_tos_nxt = r_tos + PTR_W'(1);
            w_wr_en   = 1'b1;
            w_wr_idx  = r_tos + PTR_W'(1);
            if (r_count != CNT_W'(DEPTH)) begin
                w_count_nxt = r_count + CNT_W'(1);
            end
        end else if (pop_i && w_nonempty) begin
            w_tos_nxt   = r_tos - PTR_W'(1);
            w_count_nxt = r_count - CNT_W'(1);
        end
    end

    // Next checkpoint FIFO pointers; a restore truncates the FIFO at restore_id_i.
    always_comb begin
        w_head_nxt = r_head;
        w_tail_nxt = r_tail;
        w_live_nxt = r_live;
        if (restore_i) begin
            w_tail_nxt = restore_id_i;
            w_live_nxt = {1'b0, restore_id_i - r_head};
        end else begin
            if (w_alloc_ok) begin
                w_tail_nxt = r_tail + ID_W'(1);
            end
            if (w_rel_ok) begin
                w_head_nxt = r_head + ID_W'(1);
            end
            w_live_nxt = r_live + LIVE_W'(w_alloc_ok) - LIVE_W'(w_rel_ok);
        end
    end

    // Stack storage and pointers; flush has priority over every other update.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            for (int i = 0; i < DEPTH; i++) r_entries[i] <= '0;
            r_tos   <= '0;
            r_count <= '0;
        end else if (flush_i) begin
            for (int i = 0; i < DEPTH; i++) r_entries[i] <= '0;
            r_tos   <= '0;
            r_count <= '0;
        end else begin
            if (w_wr_en) begin
                r_entries[w_wr_idx] <= w_wr_data;
            end
            r_tos   <= w_tos_nxt;
            r_count <= w_count_nxt;
        end
    end

    // Checkpoint FIFO: snapshot the pre-update stack state at the tail on alloc.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            for (int i = 0; i < NUM_CKPT; i++) r_ckpt[i] <= '0;
            r_head <= '0;
            r_tail <= '0;
            r_live <= '0;
        end else if (flush_i) begin
            for (int i = 0; i < NUM_CKPT; i++) r_ckpt[i] <= '0;
            r_head <= '0;
            r_tail <= '0;
            r_live <= '0;
        end else begin
            if (w_alloc_ok) begin
                r_ckpt[r_tail] <= '{tos: r_tos, count: r_count, top: r_entries[r_tos]};
            end
            r_head <= w_head_nxt;
            r_tail <= w_tail_nxt;
            r_live <= w_live_nxt;
        end
    end

endmodule

// File: tb/tb_nebula_ras_ckpt.sv
// Self-checking bench for nebula_ras_ckpt: directed vector table, async reset
// sequence, then randomized traffic against a queue-based reference model.
module tb_nebula_ras_ckpt;

    localparam int D  = 8;
    localparam int N  = 4;
    localparam int AW = 39;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          flush = 1'b0, push = 1'b0, pop = 1'b0;
    logic [AW-1:0] push_addr = '0;
    logic          alloc = 1'b0, restore = 1'b0, rel = 1'b0;
    logic [1:0]    restore_id = '0;
    logic [AW-1:0] top;
    logic          top_valid, full;
    logic [1:0]    ckpt_id;

    int total = 0;
    int bad   = 0;

    nebula_ras_ckpt #(.DEPTH(D), .ADDR_W(AW), .NUM_CKPT(N)) dut (
        .clk_i        (clk),
        .rst_i        (rst),
        .flush_i      (flush),
        .push_i       (push),
        .push_addr_i  (push_addr),
        .pop_i        (pop),
        .top_o        (top),
        .top_valid_o  (top_valid),
        .ckpt_alloc_i (alloc),
        .ckpt_id_o    (ckpt_id),
        .ckpt_full_o  (full),
        .restore_i    (restore),
        .restore_id_i (restore_id),
        .release_i    (rel)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s actual=0x%0h required=0x%0h", nm, act, exp);
        end
    endtask

    // ---------------- reference model ----------------
    typedef struct {
        int            tos;
        int            cnt;
        logic [AW-1:0] top;
    } snap_t;

    logic [AW-1:0] m_ent [D];
    int            m_tos, m_cnt, m_head;
    snap_t         m_q [$];

    function automatic void m_reset();
        for (int i = 0; i < D; i++) m_ent[i] = '0;
        m_tos = 0; m_cnt = 0; m_head = 0;
        m_q.delete();
    endfunction

    function automatic void m_step(input logic f, input logic pu, input logic [AW-1:0] a,
                                   input logic po, input logic al, input logic rs,
                                   input int rid, input logic rl);
        int    pre, k;
        snap_t s;
        if (f) begin
            m_reset();
            return;
        end
        if (rs) begin
            k = (rid - m_head + N) % N;
            if (k >= m_q.size()) begin
                bad++;
                $display("FAIL restore_live id=%0d live=%0d", rid, m_q.size());
                return;
            end
            s = m_q[k];
            m_tos = s.tos; m_cnt = s.cnt; m_ent[s.tos] = s.top;
            while (m_q.size() > k) void'(m_q.pop_back());
            return;
        end
        s.tos = m_tos; s.cnt = m_cnt; s.top = m_ent[m_tos];
        if (pu && po && m_cnt > 0) begin
            m_ent[m_tos] = a;
        end else if (pu) begin
            m_tos = (m_tos + 1) % D;
            m_ent[m_tos] = a;
            m_cnt = (m_cnt + 1 > D) ? D : m_cnt + 1;
        end else if (po && m_cnt > 0) begin
            m_tos = (m_tos + D - 1) % D;
            m_cnt = m_cnt - 1;
        end
        pre = m_q.size();
        if (al && pre < N) m_q.push_back(s);
        if (rl && pre > 0) begin
            void'(m_q.pop_front());
            m_head = (m_head + 1) % N;
        end
    endfunction

    // ---------------- directed vector table ----------------
    typedef struct {
        logic          f, pu;
        logic [AW-1:0] a;
        logic          po, al, rs;
        logic [1:0]    rid;
        logic          rl;
        logic [AW-1:0] e_top;
        logic          e_valid;
        logic [1:0]    e_id;
        logic          e_full;
    } vec_t;

    vec_t tbl [$];

    function automatic vec_t mk(input logic f, input logic pu, input logic [AW-1:0] a,
                                input logic po, input logic al, input logic rs,
                                input logic [1:0] rid, input logic rl,
                                input logic [AW-1:0] t, input logic v,
                                input logic [1:0] id, input logic fu);
        vec_t r;
        r.f = f; r.pu = pu; r.a = a; r.po = po; r.al = al; r.rs = rs;
        r.rid = rid; r.rl = rl; r.e_top = t; r.e_valid = v; r.e_id = id; r.e_full = fu;
        return r;
    endfunction

    task automatic drive(input logic f, input logic pu, input logic [AW-1:0] a,
                         input logic po, input logic al, input logic rs,
                         input logic [1:0] rid, input logic rl);
        flush = f; push = pu; push_addr = a; pop = po;
        alloc = al; restore = rs; restore_id = rid; rel = rl;
    endtask

    task automatic idle();
        drive(0, 0, '0, 0, 0, 0, 2'd0, 0);
    endtask

    task automatic chk_outs(input string tag, input logic [AW-1:0] t, input logic v,
                            input logic [1:0] id, input logic fu);
        chk({tag, ".top"},   64'(top),       64'(t));
        chk({tag, ".valid"}, 64'(top_valid), 64'(v));
        chk({tag, ".id"},    64'(ckpt_id),   64'(id));
        chk({tag, ".full"},  64'(full),      64'(fu));
    endtask

    initial begin
        logic [AW-1:0] ra;
        logic          rf, rpu, rpo, ral, rrs, rrl;
        int            rk;
        logic [1:0]    rrid;

        // push / pop basics
        tbl.push_back(mk(0,1,39'h100,0,0,0,0,0, 39'h100,1,0,0));
        tbl.push_back(mk(0,1,39'h200,0,0,0,0,0, 39'h200,1,0,0));
        tbl.push_back(mk(0,1,39'h300,0,0,0,0,0, 39'h300,1,0,0));
        tbl.push_back(mk(0,0,39'h0,1,0,0,0,0,   39'h200,1,0,0));
        tbl.push_back(mk(0,0,39'h0,1,0,0,0,0,   39'h100,1,0,0));
        tbl.push_back(mk(0,0,39'h0,1,0,0,0,0,   39'h0,0,0,0));
        tbl.push_back(mk(0,0,39'h0,1,0,0,0,0,   39'h0,0,0,0));
        // overflow wrap: nine pushes into eight entries
        for (int i = 1; i <= 9; i++)
            tbl.push_back(mk(0,1,39'(i*16),0,0,0,0,0, 39'(i*16),1,0,0));
        for (int i = 8; i >= 2; i--)
            tbl.push_back(mk(0,0,39'h0,1,0,0,0,0, 39'(i*16),1,0,0));
        tbl.push_back(mk(0,0,39'h0,1,0,0,0,0, 39'h90,0,0,0));
        // replace
        tbl.push_back(mk(0,1,39'hA0,0,0,0,0,0, 39'hA0,1,0,0));
        tbl.push_back(mk(0,1,39'hB0,1,0,0,0,0, 39'hB0,1,0,0));
        tbl.push_back(mk(0,0,39'h0,1,0,0,0,0,  39'h90,0,0,0));
        tbl.push_back(mk(0,1,39'hB0,1,0,0,0,0, 39'hB0,1,0,0));
        tbl.push_back(mk(0,0,39'h0,1,0,0,0,0,  39'h90,0,0,0));
        // checkpoint and restore
        tbl.push_back(mk(0,1,39'h40,0,0,0,0,0, 39'h40,1,0,0));
        tbl.push_back(mk(0,0,39'h0,0,1,0,0,0,  39'h40,1,1,0));
        tbl.push_back(mk(0,0,39'h0,1,0,0,0,0,  39'h90,0,1,0));
        tbl.push_back(mk(0,1,39'h77,0,0,0,0,0, 39'h77,1,1,0));
        tbl.push_back(mk(0,1,39'h88,0,0,0,0,0, 39'h88,1,1,0));
        tbl.push_back(mk(0,0,39'h0,0,0,1,0,0,  39'h40,1,0,0));
        tbl.push_back(mk(0,0,39'h0,1,0,0,0,0,  39'h90,0,0,0));
        // fill, drop when full, alloc+release when full, drain
        tbl.push_back(mk(0,0,39'h0,0,1,0,0,0, 39'h90,0,1,0));
        tbl.push_back(mk(0,0,39'h0,0,1,0,0,0, 39'h90,0,2,0));
        tbl.push_back(mk(0,0,39'h0,0,1,0,0,0, 39'h90,0,3,0));
        tbl.push_back(mk(0,0,39'h0,0,1,0,0,0, 39'h90,0,0,1));
        tbl.push_back(mk(0,0,39'h0,0,1,0,0,0, 39'h90,0,0,1));
        tbl.push_back(mk(0,0,39'h0,0,1,0,0,1, 39'h90,0,0,0));
        tbl.push_back(mk(0,0,39'h0,0,0,0,0,1, 39'h90,0,0,0));
        tbl.push_back(mk(0,0,39'h0,0,0,0,0,1, 39'h90,0,0,0));
        tbl.push_back(mk(0,0,39'h0,0,0,0,0,1, 39'h90,0,0,0));
        tbl.push_back(mk(0,0,39'h0,0,0,0,0,1, 39'h90,0,0,0));
        // live is zero now: exactly four more allocs reach full
        tbl.push_back(mk(0,0,39'h0,0,1,0,0,0, 39'h90,0,1,0));
        tbl.push_back(mk(0,0,39'h0,0,1,0,0,0, 39'h90,0,2,0));
        tbl.push_back(mk(0,0,39'h0,0,1,0,0,0, 39'h90,0,3,0));
        tbl.push_back(mk(0,0,39'h0,0,1,0,0,0, 39'h90,0,0,1));
        // flush beats everything
        tbl.push_back(mk(0,1,39'h55,0,0,0,0,0, 39'h55,1,0,1));
        tbl.push_back(mk(1,1,39'h66,0,1,1,2,0, 39'h0,0,0,0));

        m_reset();
        idle();
        repeat (3) @(negedge clk);
        chk_outs("reset", '0, 0, 2'd0, 0);
        rst = 1'b0;

        foreach (tbl[i]) begin
            @(negedge clk);
            drive(tbl[i].f, tbl[i].pu, tbl[i].a, tbl[i].po, tbl[i].al, tbl[i].rs,
                  tbl[i].rid, tbl[i].rl);
            @(posedge clk);
            #1;
            chk_outs($sformatf("vec%0d", i), tbl[i].e_top, tbl[i].e_valid,
                     tbl[i].e_id, tbl[i].e_full);
        end

        // async reset mid-cycle after building up state
        @(negedge clk); drive(0, 1, 39'h123, 0, 0, 0, 0, 0);
        @(negedge clk); drive(0, 0, '0, 0, 1, 0, 0, 0);
        @(negedge clk); idle();
        chk_outs("pre_rst", 39'h123, 1, 2'd1, 0);
        drive(0, 1, 39'h456, 0, 1, 0, 0, 0);
        #2 rst = 1'b1;
        #1 chk_outs("async_rst", '0, 0, 2'd0, 0);
        idle();
        @(negedge clk);
        chk_outs("rst_hold", '0, 0, 2'd0, 0);
        rst = 1'b0;

        // randomized traffic against the model
        m_reset();
        for (int c = 0; c < 3000; c++) begin
            @(negedge clk);
            ra  = AW'({$urandom(), $urandom()});
            rf  = ($urandom_range(0, 99) < 2);
            rpu = $urandom_range(0, 1) == 1;
            rpo = $urandom_range(0, 1) == 1;
            ral = ($urandom_range(0, 99) < 35);
            rrl = ($urandom_range(0, 99) < 30);
            rrs = 1'b0;
            rrid = 2'($urandom_range(0, 3));
            if (m_q.size() > 0 && $urandom_range(0, 99) < 6) begin
                rrs = 1'b1;
                rk = $urandom_range(0, m_q.size() - 1);
                rrid = 2'((m_head + rk) % N);
            end
            drive(rf, rpu, ra, rpo, ral, rrs, rrid, rrl);
            #1;
            chk("rnd.id_in_cycle", 64'(ckpt_id), 64'((m_head + m_q.size()) % N));
            @(posedge clk);
            #1;
            m_step(rf, rpu, ra, rpo, ral, rrs, int'(rrid), rrl);
            chk_outs($sformatf("rnd%0d", c), m_ent[m_tos], m_cnt != 0,
                     2'((m_head + m_q.size()) % N), m_q.size() == N);
        end
        idle();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/nebula_ras_ckpt.md
Name: nebula_ras_ckpt

Overview:
- Parametrised return address stack (RAS) for the Nebula frontend branch predictor; successor to the fixed RAS_DEPTH stack.
- Circular stack that wraps on overflow; push/pop/replace driven by fetch-stage call/return predictions.
- Adds NUM_CKPT speculative checkpoints, allocated in order at predicted branches, restored on mispredict, released in order at commit.
- Sits between the BTB/gshare lookup and the fetch PC mux; top_o feeds bp_prediction_t.target when is_ret.

Parameters:
- DEPTH, 8 (RAS_DEPTH): stack entries; power of two, >=2.
- ADDR_W, 39 (VADDR_WIDTH): return-address width.
- NUM_CKPT, 4: in-flight checkpoints; power of two, >=2.

Ports:
- clk_i  in  1  clock
- rst_i  in  1  reset; asynchronous, active-high
- flush_i  in  1  clear stack and all checkpoints
- push_i  in  1  predicted call: push push_addr_i
- push_addr_i  in  ADDR_W  return address (call PC + 2 or + 4)
- pop_i  in  1  predicted return: pop
- top_o  out  ADDR_W  current top-of-stack entry
- top_valid_o  out  1  stack non-empty
- ckpt_alloc_i  in  1  take a checkpoint this cycle
- ckpt_id_o  out  $clog2(NUM_CKPT)  id granted to the alloc (next tail index)
- ckpt_full_o  out  1  NUM_CKPT checkpoints live
- restore_i  in  1  mispredict: restore to restore_id_i
- restore_id_i  in  $clog2(NUM_CKPT)  checkpoint to restore (must be live)
- release_i  in  1  commit: free oldest checkpoint

Behaviour:
- State: entries[DEPTH], tos pointer, count (0..DEPTH, saturating), ckpt array {tos, count, top entry}, ckpt head/tail, live count.
- Reset or flush_i: tos=0, count=0, all entries=0, head=tail=live=0. Outputs: top_o=0, top_valid_o=0, ckpt_id_o=0, ckpt_full_o=0.
- top_o=entries[tos] and top_valid_o=(count!=0), both purely from registers; pushes and pops are visible the next cycle.
- Priority, highest first: flush_i > restore_i > push/pop/alloc/release. When flush_i or restore_i is asserted, push, pop, alloc and release are all ignored that cycle.
- Push only: tos=tos+1 mod DEPTH; entries[new tos]=push_addr_i; count=min(count+1, DEPTH). A push at DEPTH overwrites the oldest entry.
- Pop only: if count>0, tos=tos-1 mod DEPTH and count-1. If count==0, no state change.
- Push and pop together (replace): entries[tos]=push_addr_i, tos and count unchanged. If count==0, behaves as a push.
- Alloc:
  - Accepted only when ckpt_full_o=0, using the pre-cycle value.
  - Stores the pre-update {tos, count, entries[tos]} at tail; tail+1; live+1.
  - ckpt_id_o equals that tail index during the alloc cycle.
  - Alloc while full is dropped silently.
- Release: if live>0, head+1 and live-1; release with live==0 is ignored.
- Alloc and release in the same cycle: both take effect, so live is unchanged.
- Restore:
  - tos, count and entries[ckpt.tos] are set to the checkpoint values.
  - tail=restore_id_i. The restored checkpoint and all younger ones are freed; live=(restore_id_i - head) mod NUM_CKPT.
  - Restore of a non-live id is a protocol violation; the bench asserts against it.
- Deeper corruption beyond the top entry is tolerated; this is a prediction structure only.
- Single-cycle update on every operation; no stalls, no backpressure other than ckpt_full_o.

Decomposition:
- Add the parameter NUM_RAS_CKPT=4 to nebula_pkg.
- Add typedef ras_ckpt_t {tos, count, top} to nebula_pkg.
- No sub-module; the checkpoint FIFO is inline.

Test Plan:
- Reset, then push 0x100, 0x200, 0x300 -> top_o=0x300, top_valid_o=1. Pop x3 -> 0x200, then 0x100, then top_valid_o=0. A 4th pop -> no change.
- DEPTH=8: push 0x10..0x90 (9 pushes) -> top_o=0x90, count=8. Pop 8 times -> tops 0x80..0x20, then valid=0; 0x10 is lost.
- Push 0xA0, then push+pop with 0xB0 the same cycle -> top_o=0xB0, count unchanged. Push+pop on an empty stack -> top_o=0xB0, valid=1.
- Push 0x40, alloc (id 0), pop, push 0x77, push 0x88, restore id 0 -> top_o=0x40, count=1, live=0, next ckpt_id_o=0.
- Alloc 4 times -> ckpt_full_o=1, 5th alloc dropped. Alloc+release same cycle while full -> alloc dropped, live=3. Release x3 -> ckpt_full_o=0, live=0.
- Assert flush_i while push_i, restore_i and ckpt_alloc_i are high -> next cycle top_valid_o=0, ckpt_full_o=0, ckpt_id_o=0. Assert rst_i mid-sequence -> outputs reset asynchronously, same cycle.
